// File: rtl/semaphore_pkg.sv
// Shared encodings for the semaphore control unit and its phase timer.
package semaphore_pkg;

    localparam logic [1:0] TM_MAIN = 2'b00;
    localparam logic [1:0] TM_SEC  = 2'b01;
    localparam logic [1:0] TM_YEL  = 2'b10;

    localparam logic [1:0] SF_PGREEN  = 2'd0;
    localparam logic [1:0] SF_PYELLOW = 2'd1;
    localparam logic [1:0] SF_SGREEN  = 2'd2;
    localparam logic [1:0] SF_SYELLOW = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_LOAD = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIRE = 2'd2;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every PRESCALE enabled cycles; clear restarts the count.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick_c
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_count;

    assign o_tick_c = i_enable && (r_count == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_tick_c ? '0 : r_count + PW'(1);
        end
    end

endmodule

// File: rtl/semaphore_phase_timer.sv
// Phase sequencer: times each controller phase in prescaled ticks, pulses trigger at phase end,
// and cuts a green short once a conflicting pedestrian request has waited out the minimum green.
module semaphore_phase_timer #(
    parameter int unsigned PRESCALE   = 50000000,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MAIN_TICKS = 30,
    parameter int unsigned SEC_TICKS  = 20,
    parameter int unsigned YEL_TICKS  = 4,
    parameter int unsigned MIN_TICKS  = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       TimerMux,
    input  logic [1:0]       StateFlag,
    input  logic             hold,
    input  logic             ped_btn_main,
    input  logic             ped_btn_sec,
    output logic             trigger,
    output logic [CNT_W-1:0] remaining,
    output logic             ped_wait_main,
    output logic             ped_wait_sec
);

    import semaphore_pkg::*;

    localparam int unsigned MAIN_D = (MAIN_TICKS == 0) ? 1 : MAIN_TICKS;
    localparam int unsigned SEC_D  = (SEC_TICKS  == 0) ? 1 : SEC_TICKS;
    localparam int unsigned YEL_D  = (YEL_TICKS  == 0) ? 1 : YEL_TICKS;

    localparam logic [CNT_W-1:0] MAIN_DUR = CNT_W'(MAIN_D);
    localparam logic [CNT_W-1:0] SEC_DUR  = CNT_W'(SEC_D);
    localparam logic [CNT_W-1:0] YEL_DUR  = CNT_W'(YEL_D);

    generate
        if (PRESCALE < 2 || CNT_W < 1 || CNT_W > 31 ||
            (MAIN_D >> CNT_W) != 0 || (SEC_D >> CNT_W) != 0 || (YEL_D >> CNT_W) != 0) begin : g_bad_param
            $error("semaphore_phase_timer: PRESCALE must be >=2 and durations must fit in CNT_W bits");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_rem_nx;
    logic [CNT_W-1:0] r_dur;
    logic [CNT_W-1:0] w_dur_nx;
    logic [1:0]       r_tm;
    logic [1:0]       w_tm_nx;
    logic             r_trigger;
    logic             w_trig_nx;
    logic             r_ped_wait_main;
    logic             r_ped_wait_sec;

    logic [CNT_W-1:0] w_dur_sel;
    logic [CNT_W-1:0] w_rem_dec;
    logic [CNT_W-1:0] w_elapsed;
    logic             w_conflict;
    logic             w_cut;
    logic             w_tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk    (clock),
        .i_rst_n  (reset),
        .i_clear  (r_state == ST_LOAD),
        .i_enable ((r_state == ST_RUN) && !hold),
        .o_tick_c (w_tick)
    );

    // TimerMux 2'b11 is a second yellow code.
    always_comb begin
        case (TimerMux)
            TM_MAIN: w_dur_sel = MAIN_DUR;
            TM_SEC:  w_dur_sel = SEC_DUR;
            default: w_dur_sel = YEL_DUR;
        endcase
    end

    // Only the green being timed can be cut, and only by the crossing it blocks.
    always_comb begin
        case (r_tm)
            TM_MAIN: w_conflict = r_ped_wait_main;
            TM_SEC:  w_conflict = r_ped_wait_sec;
            default: w_conflict = 1'b0;
        endcase
    end

    assign w_rem_dec = r_remaining - CNT_W'(1);
    assign w_elapsed = r_dur - w_rem_dec;
    assign w_cut     = w_conflict && (32'(w_elapsed) >= MIN_TICKS);

    always_comb begin
        w_state_nx = r_state;
        w_rem_nx   = r_remaining;
        w_dur_nx   = r_dur;
        w_tm_nx    = r_tm;
        w_trig_nx  = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_dur_nx   = w_dur_sel;
                w_rem_nx   = w_dur_sel;
                w_tm_nx    = TimerMux;
                w_state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (w_tick) begin
                    w_rem_nx = w_rem_dec;
                    if (w_rem_dec == '0 || w_cut) begin
                        w_rem_nx   = '0;
                        w_trig_nx  = 1'b1;
                        w_state_nx = ST_FIRE;
                    end
                end
            end
            ST_FIRE: begin
                w_rem_nx   = '0;
                w_state_nx = ST_LOAD;
            end
            default: begin
                w_rem_nx   = '0;
                w_state_nx = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_LOAD;
            r_remaining <= '0;
            r_dur       <= '0;
            r_tm        <= TM_YEL;
            r_trigger   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_remaining <= w_rem_nx;
            r_dur       <= w_dur_nx;
            r_tm        <= w_tm_nx;
            r_trigger   <= w_trig_nx;
        end
    end

    // Requests clear while their own walk green is showing; clear beats a same-cycle press.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ped_wait_main <= 1'b0;
            r_ped_wait_sec  <= 1'b0;
        end else begin
            if (StateFlag == SF_SGREEN) begin
                r_ped_wait_main <= 1'b0;
            end else if (ped_btn_main) begin
                r_ped_wait_main <= 1'b1;
            end
            if (StateFlag == SF_PGREEN) begin
                r_ped_wait_sec <= 1'b0;
            end else if (ped_btn_sec) begin
                r_ped_wait_sec <= 1'b1;
            end
        end
    end

    assign trigger       = r_trigger;
    assign remaining     = r_remaining;
    assign ped_wait_main = r_ped_wait_main;
    assign ped_wait_sec  = r_ped_wait_sec;

endmodule

// File: tb/tb_semaphore_phase_timer.sv
// Directed bench for semaphore_phase_timer with PRESCALE=4, MAIN=6, SEC=5, YEL=2, MIN=3.
module tb_semaphore_phase_timer;

    localparam int unsigned CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       TimerMux;
    logic [1:0]       StateFlag;
    logic             hold = 1'b0;
    logic             ped_btn_main = 1'b0;
    logic             ped_btn_sec = 1'b0;
    logic             trigger;
    logic [CNT_W-1:0] remaining;
    logic             ped_wait_main;
    logic             ped_wait_sec;

    logic       loop_en = 1'b0;
    logic [1:0] tm_man = 2'b00;
    logic [1:0] sf_man = 2'd1;
    logic [1:0] cu_state;
    logic [1:0] cu_tm;

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] tm;
        int         cyc;
        logic       trig;
        int         rem;
    } vec_t;

    vec_t vecs[14];
    int   tcyc[8];
    int   tsf[8];
    int   ntrig;

    semaphore_phase_timer #(
        .PRESCALE   (4),
        .CNT_W      (CNT_W),
        .MAIN_TICKS (6),
        .SEC_TICKS  (5),
        .YEL_TICKS  (2),
        .MIN_TICKS  (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .TimerMux      (TimerMux),
        .StateFlag     (StateFlag),
        .hold          (hold),
        .ped_btn_main  (ped_btn_main),
        .ped_btn_sec   (ped_btn_sec),
        .trigger       (trigger),
        .remaining     (remaining),
        .ped_wait_main (ped_wait_main),
        .ped_wait_sec  (ped_wait_sec)
    );

    always #5 clock = ~clock;

    // Reference control unit for closed-loop runs: advances on trigger.
    always_ff @(posedge clock) begin
        if (!reset) cu_state <= 2'd0;
        else if (trigger) cu_state <= cu_state + 2'd1;
    end

    always_comb begin
        case (cu_state)
            2'd0:    cu_tm = 2'b00;
            2'd2:    cu_tm = 2'b01;
            default: cu_tm = 2'b10;
        endcase
    end

    assign TimerMux  = loop_en ? cu_tm : tm_man;
    assign StateFlag = loop_en ? cu_state : sf_man;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Leaves the DUT in cycle 0 (LOAD) of a fresh phase.
    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{2'b00,  1, 1'b0, 6};
        vecs[1]  = '{2'b00,  4, 1'b0, 6};
        vecs[2]  = '{2'b00,  5, 1'b0, 5};
        vecs[3]  = '{2'b00, 24, 1'b0, 1};
        vecs[4]  = '{2'b00, 25, 1'b1, 0};
        vecs[5]  = '{2'b00, 26, 1'b0, 0};
        vecs[6]  = '{2'b00, 27, 1'b0, 6};
        vecs[7]  = '{2'b01,  1, 1'b0, 5};
        vecs[8]  = '{2'b01, 20, 1'b0, 1};
        vecs[9]  = '{2'b01, 21, 1'b1, 0};
        vecs[10] = '{2'b10,  1, 1'b0, 2};
        vecs[11] = '{2'b10,  9, 1'b1, 0};
        vecs[12] = '{2'b11,  1, 1'b0, 2};
        vecs[13] = '{2'b11,  9, 1'b1, 0};

        reset = 1'b0;
        step(2);
        chk("rst_trigger", 32'(trigger), 0);
        chk("rst_remaining", 32'(remaining), 0);
        chk("rst_wait_main", 32'(ped_wait_main), 0);
        chk("rst_wait_sec", 32'(ped_wait_sec), 0);

        // Phase timing per TimerMux, no buttons, no hold.
        for (int i = 0; i < 14; i++) begin
            tm_man = vecs[i].tm;
            sf_man = 2'd1;
            do_reset();
            step(vecs[i].cyc);
            chk($sformatf("vec%0d_trigger", i), 32'(trigger), 32'(vecs[i].trig));
            chk($sformatf("vec%0d_remaining", i), 32'(remaining), 32'(vecs[i].rem));
        end

        // Closed loop: two full cycles of the control unit.
        loop_en = 1'b1;
        do_reset();
        ntrig = 0;
        for (int c = 0; c < 140; c++) begin
            if (trigger) begin
                if (ntrig < 8) begin
                    tcyc[ntrig] = c;
                    tsf[ntrig]  = int'(StateFlag);
                end
                ntrig++;
            end
            step(1);
        end
        chk("loop_trigger_count", 32'(ntrig), 8);
        begin
            int exp_cyc[8];
            exp_cyc = '{25, 35, 57, 67, 93, 103, 125, 135};
            for (int k = 0; k < 8 && k < ntrig; k++) begin
                chk($sformatf("loop_trig%0d_cycle", k), 32'(tcyc[k]), 32'(exp_cyc[k]));
                chk($sformatf("loop_trig%0d_state", k), 32'(tsf[k]), 32'(k % 4));
            end
        end
        loop_en = 1'b0;

        // Principal pedestrian request cuts the principal green after MIN ticks.
        tm_man = 2'b00;
        sf_man = 2'd0;
        do_reset();
        step(2);
        ped_btn_main = 1'b1;
        step(1);
        ped_btn_main = 1'b0;
        chk("ped_main_latched", 32'(ped_wait_main), 1);
        step(9);
        chk("ped_main_c12_trigger", 32'(trigger), 0);
        chk("ped_main_c12_remaining", 32'(remaining), 4);
        step(1);
        chk("ped_main_c13_trigger", 32'(trigger), 1);
        chk("ped_main_c13_remaining", 32'(remaining), 0);
        tm_man = 2'b10;
        sf_man = 2'd1;
        step(4);
        chk("ped_main_held_yellow", 32'(ped_wait_main), 1);
        sf_man = 2'd2;
        step(1);
        chk("ped_main_cleared", 32'(ped_wait_main), 0);
        ped_btn_main = 1'b1;
        step(1);
        ped_btn_main = 1'b0;
        chk("ped_main_walk_press", 32'(ped_wait_main), 0);

        // Secondary request: ignored in PGreen, latched in yellow, yellow not cut, then cuts SGreen.
        tm_man = 2'b00;
        sf_man = 2'd0;
        do_reset();
        step(2);
        ped_btn_sec = 1'b1;
        step(1);
        ped_btn_sec = 1'b0;
        chk("ped_sec_walk_press", 32'(ped_wait_sec), 0);
        tm_man = 2'b10;
        sf_man = 2'd1;
        do_reset();
        step(2);
        ped_btn_sec = 1'b1;
        step(1);
        ped_btn_sec = 1'b0;
        chk("ped_sec_latched", 32'(ped_wait_sec), 1);
        step(5);
        chk("ped_sec_yel_c8_trigger", 32'(trigger), 0);
        chk("ped_sec_yel_c8_remaining", 32'(remaining), 1);
        step(1);
        chk("ped_sec_yel_c9_trigger", 32'(trigger), 1);
        tm_man = 2'b01;
        sf_man = 2'd2;
        step(13);
        chk("ped_sec_grn_c22_trigger", 32'(trigger), 0);
        chk("ped_sec_grn_c22_remaining", 32'(remaining), 3);
        step(1);
        chk("ped_sec_grn_c23_trigger", 32'(trigger), 1);
        chk("ped_sec_grn_c23_wait", 32'(ped_wait_sec), 1);

        // Hold for 7 cycles mid-RUN, then hold across FIRE.
        tm_man = 2'b00;
        sf_man = 2'd1;
        do_reset();
        step(10);
        chk("hold_c10_remaining", 32'(remaining), 4);
        hold = 1'b1;
        step(7);
        chk("hold_c17_remaining", 32'(remaining), 4);
        hold = 1'b0;
        step(2);
        chk("hold_c19_remaining", 32'(remaining), 4);
        step(1);
        chk("hold_c20_remaining", 32'(remaining), 3);
        step(11);
        chk("hold_c31_trigger", 32'(trigger), 0);
        step(1);
        chk("hold_c32_trigger", 32'(trigger), 1);
        hold = 1'b1;
        step(1);
        chk("hold_fire_c33_trigger", 32'(trigger), 0);
        step(1);
        chk("hold_fire_c34_remaining", 32'(remaining), 6);
        hold = 1'b0;

        // One-cycle reset at remaining==2 discards progress and requests.
        tm_man = 2'b00;
        sf_man = 2'd1;
        do_reset();
        step(2);
        ped_btn_sec = 1'b1;
        step(1);
        ped_btn_sec = 1'b0;
        step(14);
        chk("mrst_c17_remaining", 32'(remaining), 2);
        ped_btn_main = 1'b1;
        step(1);
        ped_btn_main = 1'b0;
        chk("mrst_pre_wait_main", 32'(ped_wait_main), 1);
        chk("mrst_pre_wait_sec", 32'(ped_wait_sec), 1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("mrst_trigger", 32'(trigger), 0);
        chk("mrst_remaining", 32'(remaining), 0);
        chk("mrst_wait_main", 32'(ped_wait_main), 0);
        chk("mrst_wait_sec", 32'(ped_wait_sec), 0);
        step(1);
        chk("mrst_reload", 32'(remaining), 6);
        step(23);
        chk("mrst_c43_trigger", 32'(trigger), 0);
        step(1);
        chk("mrst_c44_trigger", 32'(trigger), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
